// File: rtl/vga_pixel_clk_gen_if.sv
// Pixel-clock bundle between the DDS clock generator and the VGA timing chain.
// The master drives the clock, its enable pulse and the lock flag; the slave consumes them.
interface vga_pixel_clk_gen_if;
  logic vga_clk;
  logic clk_en;
  logic locked;

  modport master (
    output vga_clk,
    output clk_en,
    output locked
  );

  modport slave (
    input vga_clk,
    input clk_en,
    input locked
  );
endinterface

// File: rtl/vga_pixel_clk_gen.sv
// Phase-accumulator (DDS) pixel clock generator: the accumulator MSB becomes vga_clk,
// with a single-cycle clk_en on each rising edge and a lock flag after a fixed settle count.
module vga_pixel_clk_gen #(
  parameter int unsigned IN_FREQ_HZ  = 100000000,
  parameter int unsigned OUT_FREQ_HZ = 40000000,
  parameter int          ACC_WIDTH   = 32,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic                   CLK_100MHz,
  input  logic                   reset_n,
  vga_pixel_clk_gen_if.master    pix
);

  localparam int unsigned CNT_W  = (LOCK_CYCLES < 1) ? 1 : $clog2(LOCK_CYCLES + 1);
  localparam int unsigned DIV_HZ = (IN_FREQ_HZ == 0) ? 1 : IN_FREQ_HZ;

  // Round-half-up of OUT * 2^W / IN; 128-bit math keeps 48-bit accumulators exact.
  localparam logic [127:0] INC_WIDE =
    ((128'(OUT_FREQ_HZ) << ACC_WIDTH) + 128'(DIV_HZ / 2)) / 128'(DIV_HZ);
  localparam logic [127:0] INC_MAX  = 128'(1) << (ACC_WIDTH - 1);

  localparam logic [ACC_WIDTH-1:0] INC      = INC_WIDE[ACC_WIDTH-1:0];
  localparam logic [CNT_W-1:0]     LOCK_VAL = CNT_W'(LOCK_CYCLES);

  if (ACC_WIDTH < 4 || ACC_WIDTH > 48) begin : g_bad_acc_width
    $error("vga_pixel_clk_gen: ACC_WIDTH must lie in 4..48");
  end

  if (OUT_FREQ_HZ == 0 || IN_FREQ_HZ == 0 ||
      64'(OUT_FREQ_HZ) > 64'(IN_FREQ_HZ) / 64'd2) begin : g_bad_freq
    $error("vga_pixel_clk_gen: need 0 < OUT_FREQ_HZ <= IN_FREQ_HZ/2");
  end

  if (INC_WIDE == 128'd0 || INC_WIDE > INC_MAX) begin : g_bad_inc
    $error("vga_pixel_clk_gen: phase increment out of range for ACC_WIDTH");
  end

  if (LOCK_CYCLES < 1) begin : g_bad_lock
    $error("vga_pixel_clk_gen: LOCK_CYCLES must be at least 1");
  end

  logic [ACC_WIDTH-1:0] acc_reg;
  logic [ACC_WIDTH-1:0] acc_next;
  logic [CNT_W-1:0]     cnt_reg;
  logic [CNT_W-1:0]     cnt_next;
  logic                 lock_next;
  logic                 locked_reg;
  logic                 vga_clk_reg;
  logic                 vga_clk_next;
  logic                 clk_en_reg;
  logic                 clk_en_next;

  // The accumulator free-runs through the lock interval; only the outputs are gated.
  always_comb begin
    acc_next     = acc_reg + INC;
    cnt_next     = (cnt_reg == LOCK_VAL) ? cnt_reg : cnt_reg + CNT_W'(1);
    lock_next    = (cnt_next == LOCK_VAL);
    vga_clk_next = lock_next & acc_next[ACC_WIDTH-1];
    clk_en_next  = lock_next & acc_next[ACC_WIDTH-1] & ~acc_reg[ACC_WIDTH-1];
  end

  always_ff @(posedge CLK_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      acc_reg     <= '0;
      cnt_reg     <= '0;
      locked_reg  <= 1'b0;
      vga_clk_reg <= 1'b0;
      clk_en_reg  <= 1'b0;
    end else begin
      acc_reg     <= acc_next;
      cnt_reg     <= cnt_next;
      locked_reg  <= lock_next;
      vga_clk_reg <= vga_clk_next;
      clk_en_reg  <= clk_en_next;
    end
  end

  assign pix.vga_clk = vga_clk_reg;
  assign pix.clk_en  = clk_en_reg;
  assign pix.locked  = locked_reg;

endmodule

// File: tb/tb_vga_pixel_clk_gen.sv
// Directed bench for vga_pixel_clk_gen: exact-divide, fractional and default configurations
// share one clock and reset so lock timing, rate and re-lock can be checked side by side.
module tb_vga_pixel_clk_gen;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  vga_pixel_clk_gen_if if_a ();
  vga_pixel_clk_gen_if if_b ();
  vga_pixel_clk_gen_if if_c ();

  // INC = 64: period 4, 50% duty
  vga_pixel_clk_gen #(
    .IN_FREQ_HZ (100),
    .OUT_FREQ_HZ(25),
    .ACC_WIDTH  (8),
    .LOCK_CYCLES(16)
  ) u_dut_a (
    .CLK_100MHz(clk),
    .reset_n   (reset_n),
    .pix       (if_a)
  );

  // INC = round(102.4) = 102
  vga_pixel_clk_gen #(
    .IN_FREQ_HZ (100),
    .OUT_FREQ_HZ(40),
    .ACC_WIDTH  (8),
    .LOCK_CYCLES(16)
  ) u_dut_b (
    .CLK_100MHz(clk),
    .reset_n   (reset_n),
    .pix       (if_b)
  );

  vga_pixel_clk_gen u_dut_c (
    .CLK_100MHz(clk),
    .reset_n   (reset_n),
    .pix       (if_c)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] all_outs();
    return {if_a.vga_clk, if_a.clk_en, if_a.locked,
            if_b.vga_clk, if_b.clk_en, if_b.locked,
            if_c.vga_clk, if_c.clk_en, if_c.locked};
  endfunction

  // Edges counted from reset release; acc of DUT A after edge k is 64*k mod 256.
  task automatic run_lock_seq(input string pass);
    logic exp_lock;
    logic exp_vga;
    logic exp_en;
    for (int k = 1; k <= 30; k++) begin
      step();
      exp_lock = (k >= 16);
      exp_vga  = exp_lock && (((64 * k) % 256) >= 128);
      exp_en   = exp_vga && (((64 * (k - 1)) % 256) < 128);
      $display("[TB] %s edge %0d locked=%0b vga_clk=%0b clk_en=%0b",
               pass, k, if_a.locked, if_a.vga_clk, if_a.clk_en);
      check({pass, "_a_locked"}, 64'(if_a.locked), 64'(exp_lock));
      check({pass, "_a_vga_clk"}, 64'(if_a.vga_clk), 64'(exp_vga));
      check({pass, "_a_clk_en"}, 64'(if_a.clk_en), 64'(exp_en));
      if (k == 15 || k == 16) begin
        check({pass, "_b_locked"}, 64'(if_b.locked), 64'(exp_lock));
        check({pass, "_c_locked"}, 64'(if_c.locked), 64'(exp_lock));
      end
    end
  endtask

  initial begin
    logic b_prev;
    logic c_prev_en;
    logic a_prev;
    int   b_rises, b_pulses, b_run, b_maxrun, b_minrun, b_runs_seen;
    int   a_rises;
    int   c_pulses, c_double;

    reset_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      $display("[TB] reset hold cycle %0d outs=%b", i, all_outs());
      check("rst_hold_outs", 64'(all_outs()), 64'd0);
    end

    reset_n = 1'b1;
    run_lock_seq("lock1");

    b_prev      = if_b.vga_clk;
    a_prev      = if_a.vga_clk;
    c_prev_en   = if_c.clk_en;
    b_rises     = 0;
    b_pulses    = 0;
    b_run       = 0;
    b_maxrun    = 0;
    b_minrun    = 1000;
    b_runs_seen = 0;
    a_rises     = 0;
    c_pulses    = 0;
    c_double    = 0;
    for (int i = 1; i <= 10000; i++) begin
      step();
      if (i <= 256) begin
        if (if_b.vga_clk && !b_prev) b_rises++;
        if (if_b.clk_en) b_pulses++;
        if (if_a.vga_clk && !a_prev) a_rises++;
        if (if_b.vga_clk == b_prev) begin
          b_run++;
        end else begin
          // the first run is truncated by the window start, so skip it
          if (b_runs_seen > 0) begin
            if (b_run > b_maxrun) b_maxrun = b_run;
            if (b_run < b_minrun) b_minrun = b_run;
          end
          b_runs_seen++;
          b_run = 1;
        end
      end
      if (if_c.clk_en) c_pulses++;
      if (if_c.clk_en && c_prev_en) c_double++;
      b_prev    = if_b.vga_clk;
      a_prev    = if_a.vga_clk;
      c_prev_en = if_c.clk_en;
    end
    $display("[TB] window b_rises=%0d b_pulses=%0d b_run=[%0d..%0d] a_rises=%0d c_pulses=%0d",
             b_rises, b_pulses, b_minrun, b_maxrun, a_rises, c_pulses);
    check("b_rises_256", 64'(b_rises), 64'd102);
    check("b_pulses_256", 64'(b_pulses), 64'd102);
    check("b_maxrun_le2", 64'(b_maxrun <= 2), 64'd1);
    check("b_minrun_ge1", 64'(b_minrun >= 1), 64'd1);
    check("a_rises_256", 64'(a_rises), 64'd64);
    check("c_pulses_10000", 64'(c_pulses >= 3999 && c_pulses <= 4001), 64'd1);
    check("c_no_double_en", 64'(c_double), 64'd0);
    check("c_locked_run", 64'(if_c.locked), 64'd1);

    #3;
    reset_n = 1'b0;
    #1;
    $display("[TB] async reset mid-cycle outs=%b", all_outs());
    check("async_rst_outs", 64'(all_outs()), 64'd0);
    step();
    check("rst_pulse_edge_outs", 64'(all_outs()), 64'd0);
    reset_n = 1'b1;
    run_lock_seq("lock2");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
